// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions used by the AXI4-Lite RAM and the adapter blocks.
//   RESP_OKAY   : normal completion response code
//   RESP_SLVERR : responder error response code
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axil_pkg

// File: rtl/axil_ram.sv
// AXI4-Lite responder backed by an on-chip word-addressed RAM.
//
// Write and read channels are fully independent and may both complete in the
// same cycle. A write is taken only when AW and W are both valid (never one
// channel alone) and at most one B response is outstanding. Reads have a
// one-cycle latency and sustain one read per cycle while rready is high.
// A read and a write to the same word accepted together return the old word.
//
// Optional build macro:
//   AXIL_RAM_PIPELINE_OUTPUT_EN - adds an output register stage on the read
//                                 path (two-cycle read latency, full throughput
//                                 kept by a two-entry skid).
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   s_axil_aw* / s_axil_w* / s_axil_b*   write address, data and response
//   s_axil_ar* / s_axil_r*               read address and data
//   awprot/arprot are accepted but ignored; bresp/rresp are always OKAY.
module axil_ram
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int WORD_AW  = ADDR_WIDTH - ADDR_LSB;
    localparam int DEPTH    = 2 ** WORD_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [WORD_AW-1:0]    wr_idx;
    logic [WORD_AW-1:0]    rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  out_free;

    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

`ifdef AXIL_RAM_PIPELINE_OUTPUT_EN
    logic                  pipe_valid_q, pipe_valid_d;
    logic [DATA_WIDTH-1:0] pipe_data_q,  pipe_data_d;
    logic                  pipe_load;
`endif

    // Byte-offset bits and protection fields carry no meaning for this RAM.
    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};

    assign wr_idx = s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];

    // Combinational read of the pre-edge contents; since the array is only
    // updated at the clock edge, a same-cycle write is not visible here.
    assign rd_word = mem[rd_idx];

    // AW and W are accepted as a pair, and only when the B slot is free or
    // being retired this very cycle.
    assign wr_accept = !rst && s_axil_awvalid && s_axil_wvalid &&
                       (!s_axil_bvalid || s_axil_bready);

    // Output register can take a new word when empty or being drained.
    assign out_free = !rvalid_q || s_axil_rready;

`ifdef AXIL_RAM_PIPELINE_OUTPUT_EN
    // Pipe stage can load when empty or when it moves forward this cycle.
    assign pipe_load      = !pipe_valid_q || out_free;
    assign s_axil_arready = !rst && pipe_load;
`else
    assign s_axil_arready = !rst && out_free;
`endif
    assign rd_accept = s_axil_arvalid && s_axil_arready;

    assign s_axil_awready = wr_accept;
    assign s_axil_wready  = wr_accept;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = RESP_OKAY;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = RESP_OKAY;

    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can leave it
        // unassigned and infer a latch.
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;

        if (wr_accept) begin
            bvalid_d = 1'b1;
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end

`ifdef AXIL_RAM_PIPELINE_OUTPUT_EN
        pipe_valid_d = pipe_valid_q;
        pipe_data_d  = pipe_data_q;

        if (out_free) begin
            rvalid_d = pipe_valid_q;
            if (pipe_valid_q) begin
                rdata_d = pipe_data_q;
            end
        end

        if (pipe_load) begin
            pipe_valid_d = rd_accept;
            if (rd_accept) begin
                pipe_data_d = rd_word;
            end
        end
`else
        if (out_free) begin
            rvalid_d = rd_accept;
            if (rd_accept) begin
                rdata_d = rd_word;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
`ifdef AXIL_RAM_PIPELINE_OUTPUT_EN
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
`endif
        end else begin
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
`ifdef AXIL_RAM_PIPELINE_OUTPUT_EN
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; clearing it would prevent RAM
    // inference and its contents are defined only once written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axil_wstrb[i]) begin
                    mem[wr_idx][8*i +: 8] <= s_axil_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule : axil_ram

// File: tb/tb_axil_ram.sv
// Self-checking bench for axil_ram (32-bit data, 16-bit byte address).
// Expected data comes from a word-indexed associative-array model of memory;
// read latency expectation follows AXIL_RAM_PIPELINE_OUTPUT_EN.
module tb_axil_ram;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;

`ifdef AXIL_RAM_PIPELINE_OUTPUT_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    axil_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (awaddr),
        .s_axil_awprot (awprot),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata  (wdata),
        .s_axil_wstrb  (wstrb),
        .s_axil_wvalid (wvalid),
        .s_axil_wready (wready),
        .s_axil_bresp  (bresp),
        .s_axil_bvalid (bvalid),
        .s_axil_bready (bready),
        .s_axil_araddr (araddr),
        .s_axil_arprot (arprot),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata  (rdata),
        .s_axil_rresp  (rresp),
        .s_axil_rvalid (rvalid),
        .s_axil_rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference memory: word index -> 32-bit word.
    logic [31:0] ref_mem [int];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int          idx = int'(addr) / 4;
        logic [31:0] word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
        ref_mem[idx] = word;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
        int idx = int'(addr) / 4;
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write: present AW+W together, wait for accept, retire B at once.
    task automatic write_txn(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        while (!(awready && wready) && n < 20) begin
            tick();
            n++;
        end
        check("wr_handshake", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(addr, data, strb);
        check("bvalid_after_wr", bvalid, 1'b1);
        check("bresp", bresp, 2'b00);
        tick();
    endtask

    task automatic read_txn(input logic [AW-1:0] addr);
        int          n = 0;
        int          lat;
        logic [31:0] exp;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        #1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        check("ar_handshake", arready, 1'b1);
        exp = model_read(addr);
        tick();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 10) begin
            tick();
            lat++;
        end
        check("rd_latency", lat, READ_LAT);
        check("rdata", rdata, exp);
        check("rresp", rresp, 2'b00);
        tick();
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    // Stream nreads reads of random words 0..99 (random byte offsets); rready
    // random or held high. In the held-high case arready must never drop.
    task automatic read_stream(input int nreads, input bit rand_ready);
        logic [31:0] expq[$];
        logic [31:0] held;
        bit          hold_pending = 1'b0;
        bit          ar_done = 1'b0;
        int          issued = 0;
        int          got = 0;
        int          cyc = 0;
        arvalid = 1'b0;
        while (got < nreads && cyc < 5000) begin
            if (ar_done || !arvalid) begin
                if (issued < nreads) begin
                    araddr  = AW'($urandom_range(0, 99) * 4 + $urandom_range(0, 3));
                    arvalid = 1'b1;
                end else begin
                    arvalid = 1'b0;
                end
            end
            rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!rand_ready && arvalid)
                check("ar_full_throughput", arready, 1'b1);
            if (hold_pending) begin
                check("rvalid_held", rvalid, 1'b1);
                check("rdata_held", rdata, held);
            end
            if (rvalid && rready) begin
                check("r_expected", expq.size() != 0, 1'b1);
                if (expq.size() != 0) check("stream_rdata", rdata, expq.pop_front());
                got++;
            end
            hold_pending = rvalid && !rready;
            held = rdata;
            ar_done = arvalid && arready;
            if (ar_done) begin
                expq.push_back(model_read(araddr));
                issued++;
            end
            tick();
            cyc++;
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        check("stream_count", got, nreads);
        tick();
    endtask

    initial begin
        logic [31:0] exp_r;
        int          lat;

        rst = 1'b1;
        awaddr = '0; awprot = 3'b000; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;

        // Reset: valids high must not be accepted while rst is asserted.
        repeat (3) tick();
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Full write then read back.
        write_txn(16'h0010, 32'hDEADBEEF, 4'hF);
        read_txn(16'h0010);
        check("t1_literal", rdata, 32'hDEADBEEF);

        // Single-byte strobe merge.
        write_txn(16'h0010, 32'h0000AA00, 4'b0010);
        read_txn(16'h0010);
        check("t2_literal", model_read(16'h0010), 32'hDEADAAEF);

        // AW alone must wait for W; single accept, single B.
        awaddr = 16'h0040; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("aw_alone_awready", awready, 1'b0);
            check("aw_alone_wready", wready, 1'b0);
            check("aw_alone_bvalid", bvalid, 1'b0);
            tick();
        end
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        #1;
        check("aw_w_join_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(16'h0040, 32'hCAFEF00D, 4'hF);
        check("aw_w_join_bvalid", bvalid, 1'b1);
        tick();
        check("single_b_1", bvalid, 1'b0);
        tick();
        check("single_b_2", bvalid, 1'b0);
        read_txn(16'h0040);

        // Back-pressured B blocks the next write until bready.
        awaddr = 16'h0030; wdata = 32'h30303030; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        check("bp_first_accept", awready, 1'b1);
        tick();
        model_write(16'h0030, 32'h30303030, 4'hF);
        awaddr = 16'h0034; wdata = 32'h34343434;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_bvalid_held", bvalid, 1'b1);
            check("bp_awready_blocked", awready, 1'b0);
            tick();
        end
        bready = 1'b1;
        #1;
        check("bp_retire_and_accept", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(16'h0034, 32'h34343434, 4'hF);
        check("bp_second_bvalid", bvalid, 1'b1);
        tick();
        check("bp_bvalid_done", bvalid, 1'b0);
        read_txn(16'h0030);
        read_txn(16'h0034);

        // Same-cycle write and read of one word: read returns the old word.
        write_txn(16'h0020, 32'h22222222, 4'hF);
        awaddr = 16'h0020; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'h0020; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        #1;
        check("rw_same_awready", awready, 1'b1);
        check("rw_same_arready", arready, 1'b1);
        exp_r = model_read(16'h0020);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(16'h0020, 32'h11111111, 4'hF);
        check("rw_same_bvalid", bvalid, 1'b1);
        lat = 1;
        while (!rvalid && lat < 10) begin
            tick();
            lat++;
        end
        check("rw_same_latency", lat, READ_LAT);
        check("rw_same_old_data", rdata, exp_r);
        tick();
        read_txn(16'h0020);

        // Zero strobe: handshake and B complete, word unchanged.
        write_txn(16'h0020, 32'hFFFFFFFF, 4'h0);
        read_txn(16'h0020);

        // Reset with B and R pending: both dropped; committed write survives.
        awaddr = 16'h0050; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 16'h0010; arvalid = 1'b1; rready = 1'b0;
        #1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(16'h0050, 32'h5A5A5A5A, 4'hF);
        repeat (READ_LAT - 1) tick();
        check("pre_rst_bvalid", bvalid, 1'b1);
        check("pre_rst_rvalid", rvalid, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_rvalid", rvalid, 1'b0);
        check("mid_rst_arready", arready, 1'b0);
        rst = 1'b0; bready = 1'b1; rready = 1'b1;
        tick();
        read_txn(16'h0050);

        // Fill words 0..99, then random partial-strobe overwrites.
        for (int w = 0; w < 100; w++)
            write_txn(AW'(w * 4), $urandom, 4'hF);
        for (int k = 0; k < 30; k++)
            write_txn(AW'($urandom_range(0, 99) * 4 + $urandom_range(0, 3)), $urandom,
                      4'($urandom_range(0, 15)));

        // Streaming reads: random rready, then full throughput.
        read_stream(100, 1'b1);
        read_stream(16, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_mis++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog");
    end

endmodule : tb_axil_ram
